fix_seq_checker: RTL
====================

# fix_seq_checker

Inbound MsgSeqNum (tag 34) checker that sits directly upstream of `sequence_generator`. It converts the ASCII seq-number field streamed from the tag/value decoder into binary and compares it with `expected_seq_num_o` from `sequence_generator`. It then produces the `receiev_new_message_i`, `message_valid_i` and `igonre_i` strobes that advance the remote counter. It also flags gaps (with a resend range) and too-low sequence numbers for the session layer.

## Interface
- MAX_SIZE, 8, width of sequence numbers; must match `sequence_generator`.
- MAX_DIGITS, 3, max ASCII digits accepted in the tag 34 value.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- msg_start_i  in  1  pulse; first byte of a new message.
- msg_end_i  in  1  pulse; message complete (checksum field consumed).
- checksum_ok_i  in  1  qualifies msg_end_i; 1 = checksum matched.
- data_valid_i  in  1  data_i holds a value byte this cycle.
- data_i  in  8  ASCII value byte.
- seq_field_i  in  1  current data_i belongs to the tag 34 value.
- posdup_field_i  in  1  current data_i belongs to the tag 43 value.
- expected_seq_num_i  in  MAX_SIZE  from `sequence_generator` `expected_seq_num_o`.
- receive_new_message_o  out  1  pulse to `receiev_new_message_i`.
- message_valid_o  out  1  to `message_valid_i`; qualified by receive_new_message_o.
- ignore_o  out  1  to `igonre_i`; qualified by receive_new_message_o.
- seq_num_o  out  MAX_SIZE  last parsed MsgSeqNum.
- gap_o  out  1  pulse; received > expected.
- resend_begin_o  out  MAX_SIZE  gap start (= expected).
- resend_end_o  out  MAX_SIZE  gap end (= received − 1).
- seq_too_low_o  out  1  pulse; received < expected and not PossDup.
- busy_o  out  1  high in IN_MSG.

## Operation
- FSM states are IDLE, IN_MSG and REPORT.
  - IDLE → IN_MSG on msg_start_i.
  - IN_MSG → REPORT on msg_end_i.
  - IN_MSG → IN_MSG (accumulator cleared, current message dropped silently) on msg_start_i without msg_end_i.
  - REPORT → IN_MSG if msg_start_i, else IDLE.
- msg_start_i and msg_end_i in the same IN_MSG cycle: the end closes the current message (→ REPORT). The start is latched, and REPORT goes to IN_MSG with a cleared accumulator.
- msg_end_i in IDLE or REPORT is ignored.
- Digit accumulation occurs on data_valid_i & seq_field_i in IN_MSG: acc = acc*10 + (data_i − 8'h30).
  - acc is MAX_SIZE+4 bits wide.
  - parse_err is set on a non-digit byte, a digit count > MAX_DIGITS, acc > 2^MAX_SIZE − 1, or a second tag 34 field (seq field reopened after closing).
- PossDup: on data_valid_i & posdup_field_i, posdup = (data_i == "Y").
- Decision is registered into the REPORT cycle (rcv = acc, exp = expected_seq_num_i sampled on the msg_end_i cycle):
  - !checksum_ok_i, parse_err, or no tag 34 seen: valid=0, ignore=1.
  - rcv == exp: valid=1, ignore=0 (generator advances).
  - rcv > exp: valid=1, ignore=1, gap_o=1, resend_begin_o=exp, resend_end_o=rcv−1.
  - rcv < exp and posdup: valid=1, ignore=1, duplicate silently dropped.
  - rcv < exp and !posdup: valid=1, ignore=1, seq_too_low_o=1.
- seq_num_o updates in REPORT only when parse succeeded.
- Comparisons are unsigned at MAX_SIZE bits. There is no wrap-around: rcv = 0 with exp = 2^MAX_SIZE − 1 is too-low.

## Timing
- Latency: msg_end_i at cycle N → receive_new_message_o, message_valid_o, ignore_o, gap_o and seq_too_low_o high at N+1 for exactly one cycle, then 0.
- seq_num_o, resend_begin_o and resend_end_o are registered and hold until the next REPORT.
- Reset values: every output is 0; the FSM is in IDLE; acc, posdup and parse_err are 0.
- Reset asserted mid-message discards the message, and no receive_new_message_o is issued.
- Back-to-back: msg_start_i is accepted in the REPORT cycle, with zero idle cycles between messages.

## Configuration
- FIX_SEQ_POSDUP_EN defined: tag 43 handling as above.
- FIX_SEQ_POSDUP_EN undefined: the posdup_field_i port remains but is ignored, posdup is tied to 0, and every rcv < exp asserts seq_too_low_o.

## Test plan
- exp=5, message "34=5", checksum_ok → N+1: receive=1, valid=1, ignore=0, seq_num_o=5.
- exp=5, "34=9" → gap_o=1, resend_begin_o=5, resend_end_o=8, valid=1, ignore=1.
- exp=7, "34=3" with "43=Y" → valid=1, ignore=1, seq_too_low_o=0. Same stimulus without FIX_SEQ_POSDUP_EN → seq_too_low_o=1.
- MAX_SIZE=8, "34=300", "34=1A" and checksum_ok_i=0 cases → each gives valid=0, ignore=1, and seq_num_o unchanged.
- msg_start_i mid-message with no end, then a full "34=5" message at exp=5 → exactly one receive pulse, valid=1, ignore=0.
- rst low during IN_MSG → all outputs 0, no pulse, and the next message parses normally.

Source files
------------

// File: rtl/fix_seq_checker_if.sv
// Tag/value decoder and sequence_generator side of the inbound MsgSeqNum checker.
// master = decoder/session side, slave = fix_seq_checker.
interface fix_seq_checker_if #(
  parameter int MAX_SIZE = 8
);
  logic                msg_start_i;
  logic                msg_end_i;
  logic                checksum_ok_i;
  logic                data_valid_i;
  logic [7:0]          data_i;
  logic                seq_field_i;
  logic                posdup_field_i;
  logic [MAX_SIZE-1:0] expected_seq_num_i;

  logic                receive_new_message_o;
  logic                message_valid_o;
  logic                ignore_o;
  logic [MAX_SIZE-1:0] seq_num_o;
  logic                gap_o;
  logic [MAX_SIZE-1:0] resend_begin_o;
  logic [MAX_SIZE-1:0] resend_end_o;
  logic                seq_too_low_o;
  logic                busy_o;

  modport master (
    output msg_start_i, msg_end_i, checksum_ok_i, data_valid_i, data_i,
           seq_field_i, posdup_field_i, expected_seq_num_i,
    input  receive_new_message_o, message_valid_o, ignore_o, seq_num_o,
           gap_o, resend_begin_o, resend_end_o, seq_too_low_o, busy_o
  );

  modport slave (
    input  msg_start_i, msg_end_i, checksum_ok_i, data_valid_i, data_i,
           seq_field_i, posdup_field_i, expected_seq_num_i,
    output receive_new_message_o, message_valid_o, ignore_o, seq_num_o,
           gap_o, resend_begin_o, resend_end_o, seq_too_low_o, busy_o
  );
endinterface

// File: rtl/fix_seq_checker.sv
// Inbound MsgSeqNum (tag 34) checker: ASCII->binary, compare to expected, emit generator strobes.
// FIX_SEQ_POSDUP_EN enables PossDup (tag 43) suppression of seq_too_low_o.
module fix_seq_checker #(
  parameter int MAX_SIZE   = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  fix_seq_checker_if.slave bus
);
  localparam int AW = MAX_SIZE + 4;
  localparam int WW = MAX_SIZE + 8;
  localparam int CW = $clog2(MAX_DIGITS + 1) + 1;
  localparam logic [WW-1:0] SEQ_MAX = {{(WW-MAX_SIZE){1'b0}}, {MAX_SIZE{1'b1}}};

  typedef enum logic [1:0] {IDLE, IN_MSG, REPORT} state_t;

  state_t              state_q, state_d;
  logic                start_pend_q;
  logic [AW-1:0]       acc_q;
  logic [CW-1:0]       cnt_q;
  logic                perr_q, seen_q, in_seq_q, posdup_q;

  logic                in_msg, clr, fire, ok, is_digit;
  logic [3:0]          digit;
  logic [WW-1:0]       acc_next;
  logic [MAX_SIZE-1:0] rcv, exp_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.msg_start_i) state_d = IN_MSG;
      IN_MSG:  if (bus.msg_end_i) state_d = REPORT;
      REPORT:  state_d = (bus.msg_start_i || start_pend_q) ? IN_MSG : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign in_msg   = (state_q == IN_MSG);
  assign fire     = in_msg && bus.msg_end_i;
  // Entering IN_MSG, or a restart inside it, starts a fresh message.
  assign clr      = (state_d == IN_MSG) && (!in_msg || (bus.msg_start_i && !bus.msg_end_i));
  assign is_digit = (bus.data_i >= 8'h30) && (bus.data_i <= 8'h39);
  assign digit    = 4'(bus.data_i - 8'h30);
  assign acc_next = WW'(acc_q) * WW'(10) + WW'(digit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
      seen_q   <= 1'b0;
      in_seq_q <= 1'b0;
      posdup_q <= 1'b0;
    end else if (clr) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
      seen_q   <= 1'b0;
      in_seq_q <= 1'b0;
      posdup_q <= 1'b0;
    end else if (in_msg && bus.data_valid_i && !bus.msg_end_i) begin
      in_seq_q <= bus.seq_field_i;
      if (bus.seq_field_i) begin
        seen_q <= 1'b1;
        // A seq byte after the seq field has closed means a second tag 34.
        if (seen_q && !in_seq_q)
          perr_q <= 1'b1;
        else if (!is_digit || cnt_q >= CW'(MAX_DIGITS) || acc_next > SEQ_MAX)
          perr_q <= 1'b1;
        else begin
          acc_q <= acc_next[AW-1:0];
          cnt_q <= cnt_q + CW'(1);
        end
      end
`ifdef FIX_SEQ_POSDUP_EN
      if (bus.posdup_field_i) posdup_q <= (bus.data_i == 8'h59);
`endif
    end
  end

`ifndef FIX_SEQ_POSDUP_EN
  logic unused_posdup;
  assign unused_posdup = bus.posdup_field_i;
`endif

  assign ok    = bus.checksum_ok_i && seen_q && !perr_q;
  assign rcv   = acc_q[MAX_SIZE-1:0];
  assign exp_s = bus.expected_seq_num_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.receive_new_message_o <= 1'b0;
      bus.message_valid_o       <= 1'b0;
      bus.ignore_o              <= 1'b0;
      bus.gap_o                 <= 1'b0;
      bus.seq_too_low_o         <= 1'b0;
      bus.seq_num_o             <= '0;
      bus.resend_begin_o        <= '0;
      bus.resend_end_o          <= '0;
      start_pend_q              <= 1'b0;
    end else begin
      bus.receive_new_message_o <= fire;
      bus.message_valid_o       <= fire && ok;
      bus.ignore_o              <= fire && !(ok && rcv == exp_s);
      bus.gap_o                 <= fire && ok && (rcv > exp_s);
      bus.seq_too_low_o         <= fire && ok && (rcv < exp_s) && !posdup_q;
      if (fire && ok) bus.seq_num_o <= rcv;
      if (fire && ok && rcv > exp_s) begin
        bus.resend_begin_o <= exp_s;
        bus.resend_end_o   <= rcv - MAX_SIZE'(1);
      end
      // Start coinciding with end opens the next message right after REPORT.
      start_pend_q <= fire && bus.msg_start_i;
    end
  end

  assign bus.busy_o = in_msg;
endmodule
